// File: rtl/core_run_controller.sv
// rtl/core_run_controller.sv - sequences one core run: reset hold, run, settle, graded verdict.
// Single FSM with registered outputs; phase_q is reused as the hold, run and settle counter.
module core_run_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int RESET_CYCLES   = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  check_en,
  input  logic [DATA_WIDTH-1:0] expected_res,
  output logic                  core_reset,
  input  logic                  io_coreDone,
  input  logic [DATA_WIDTH-1:0] io_gpRegVal,
  input  logic [DATA_WIDTH-1:0] io_check_res,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [DATA_WIDTH-1:0] fail_code,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  typedef enum logic [2:0] {IDLE, HOLD_RST, RUN, SETTLE, DONE} state_t;

  state_t                state_q;
  logic [31:0]           phase_q;
  logic                  core_reset_q, busy_q, done_q, pass_q, timeout_q;
  logic [DATA_WIDTH-1:0] fail_code_q, expected_q;
  logic [CNT_WIDTH-1:0]  cycle_count_q;
  logic                  check_en_q;

  logic                  gp_ok, chk_ok, pass_d;
  logic [DATA_WIDTH-1:0] fail_code_d;
  logic [CNT_WIDTH-1:0]  cycle_count_d;

  // Verdict from whatever the core presents on the evaluating edge.
  always_comb begin
    gp_ok         = (io_gpRegVal == DATA_WIDTH'(1));
    chk_ok        = !check_en_q || (io_check_res == expected_q);
    pass_d        = gp_ok && chk_ok;
    fail_code_d   = '0;
    if (!pass_d) fail_code_d = gp_ok ? DATA_WIDTH'(1) : (io_gpRegVal >> 1);
    cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      core_reset_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_code_q   <= '0;
      cycle_count_q <= '0;
      check_en_q    <= 1'b0;
      expected_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q       <= HOLD_RST;
            phase_q       <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_code_q   <= '0;
            cycle_count_q <= '0;
            check_en_q    <= check_en;
            expected_q    <= expected_res;
          end
        end
        HOLD_RST: begin
          if (phase_q == 32'(RESET_CYCLES - 1)) begin
            state_q      <= RUN;
            phase_q      <= '0;
            core_reset_q <= 1'b0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        RUN: begin
          cycle_count_q <= cycle_count_d;
          // io_coreDone takes priority over a coincident timeout.
          if (io_coreDone) begin
            phase_q <= '0;
            if (SETTLE_CYCLES > 0) begin
              state_q <= SETTLE;
            end else begin
              state_q      <= DONE;
              core_reset_q <= 1'b1;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              pass_q       <= pass_d;
              fail_code_q  <= fail_code_d;
            end
          end else if (phase_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_q      <= DONE;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b1;
            fail_code_q  <= '1;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        SETTLE: begin
          if (phase_q == 32'(SETTLE_CYCLES - 1)) begin
            state_q      <= DONE;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            pass_q       <= pass_d;
            fail_code_q  <= fail_code_d;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_core_run_controller.sv
// tb/tb_core_run_controller.sv - directed and randomized runs graded against a verdict model.
module tb_core_run_controller;

  localparam int DW  = 32;
  localparam int RST = 8;
  localparam int STL = 4;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          reset, start, check_en, core_reset, io_coreDone;
  logic [DW-1:0] expected_res, io_gpRegVal, io_check_res, fail_code;
  logic          busy, done, pass, timeout;
  logic [31:0]   cycle_count;

  int checks = 0;
  int failures = 0;

  core_run_controller #(
    .DATA_WIDTH(DW), .RESET_CYCLES(RST), .SETTLE_CYCLES(STL),
    .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .check_en(check_en),
    .expected_res(expected_res), .core_reset(core_reset),
    .io_coreDone(io_coreDone), .io_gpRegVal(io_gpRegVal),
    .io_check_res(io_check_res), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .fail_code(fail_code), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    chk({tag, "_fail_code"}, 64'(fail_code), 64'd0);
    chk({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
  endtask

  // lat: RUN cycles after core_reset falls before io_coreDone rises; <0 means never.
  task automatic run(input int lat, input logic [DW-1:0] gp, input logic ce,
                     input logic [DW-1:0] er, input logic [DW-1:0] cr,
                     input bit stale, input bit poke, input bit abort);
    int n, k;
    bit exp_to;
    int exp_cnt;
    logic exp_pass;
    logic [DW-1:0] exp_fc;
    if (lat < 0 || lat + 1 > TMO) begin
      exp_to = 1; exp_cnt = TMO; exp_pass = 0; exp_fc = '1;
    end else begin
      exp_to = 0; exp_cnt = lat + 1;
      exp_pass = (gp == 1) && (!ce || cr == er);
      exp_fc = exp_pass ? 0 : ((gp != 1) ? (gp >> 1) : 1);
    end
    io_gpRegVal = gp; io_check_res = cr;
    @(negedge clk); start = 1; check_en = ce; expected_res = er; io_coreDone = stale;
    @(negedge clk); start = 0; check_en = ~ce; expected_res = $urandom;
    n = 0;
    while (core_reset === 1'b1 && n < 50) begin n++; @(negedge clk); end
    chk("hold_cycles", 64'(n), 64'(RST));
    chk("busy_in_run", 64'(busy), 64'd1);
    io_coreDone = 0;
    if (lat >= 0) begin
      for (int i = 0; i < lat; i++) begin start = poke && (i == 2); @(negedge clk); end
    end
    start = 0;
    if (!exp_to) io_coreDone = 1;
    if (abort) begin
      repeat (2) @(negedge clk);
      reset = 1; @(negedge clk); reset = 0;
      chk_idle("abort");
      io_coreDone = 0;
      return;
    end
    k = 0;
    while (done !== 1'b1 && k < TMO + 50) begin @(negedge clk); k++; end
    chk("done_seen", 64'(done), 64'd1);
    if (!exp_to) chk("done_latency", 64'(k), 64'(STL + 1));
    chk("pass", 64'(pass), 64'(exp_pass));
    chk("timeout", 64'(timeout), 64'(exp_to));
    chk("fail_code", 64'(fail_code), 64'(exp_fc));
    chk("cycle_count", 64'(cycle_count), 64'(exp_cnt));
    chk("core_reset_done", 64'(core_reset), 64'd1);
    chk("busy_done", 64'(busy), 64'd0);
    io_coreDone = 0;
    repeat (3) @(negedge clk);
    chk("done_sticky", 64'(done), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] g, e, c;
    reset = 1; start = 0; check_en = 0; expected_res = 0;
    io_coreDone = 0; io_gpRegVal = 0; io_check_res = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk_idle("reset");

    run(50, 32'h1, 0, 0, 0, 0, 0, 0);
    run(50, 32'hB, 0, 0, 0, 0, 0, 0);
    run(50, 32'h1, 1, 32'h1234, 32'h1235, 0, 0, 0);
    run(50, 32'h1, 1, 32'h1234, 32'h1234, 0, 0, 0);
    run(-1, 32'h1, 0, 0, 0, 0, 0, 0);
    run(TMO - 1, 32'h1, 0, 0, 0, 0, 0, 0);
    run(0, 32'h7, 0, 0, 0, 0, 0, 0);
    run(30, 32'h1, 0, 0, 0, 1, 1, 0);
    run(50, 32'h1, 0, 0, 0, 0, 0, 1);
    run(20, 32'h1, 1, 32'hCAFE, 32'hCAFE, 0, 0, 0);

    for (int it = 0; it < 12; it++) begin
      g = ($urandom_range(0, 2) == 0) ? $urandom : 32'h1;
      e = $urandom;
      c = $urandom_range(0, 1) ? e : (e ^ (32'h1 << $urandom_range(0, 31)));
      run(int'($urandom_range(0, 110)), g, 1'($urandom_range(0, 1)), e, c, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
